time_set_ctrl: RTL
==================

# time_set_ctrl

Sequencing controller for the digital clock's time counters. It owns the 1 s timebase and the set-mode state machine, and debounces the three user pushbuttons. It issues single-cycle command pulses (tick, minute increment, hour increment, seconds clear) that the hour/min/sec counter block consumes. This removes raw, undebounced pushbutton levels and the free-running prescaler from the counter datapath.

## Interface
Parameters:
- TICK_CYC, 100000000: clock cycles per 1 s tick.
- DEBOUNCE_CYC, 1000000: cycles an input must stay stable before it is accepted.
- REPEAT_DELAY_CYC, 50000000: hold time before auto-repeat starts.
- REPEAT_RATE_CYC, 10000000: auto-repeat pulse period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  timebase run enable
- btn_set  in  1  raw pushbutton, toggles set mode
- btn_hr  in  1  raw pushbutton, hour adjust
- btn_min  in  1  raw pushbutton, minute adjust
- tick_1s  out  1  one-cycle pulse, advance seconds
- min_inc  out  1  one-cycle pulse, minute +1 (wrap is handled by the counters)
- hr_inc  out  1  one-cycle pulse, hour +1
- sec_clr  out  1  one-cycle pulse, seconds to 0
- set_mode  out  1  high while in any SET state

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- Press = rising edge of the debounced level. Release = falling edge.
- FSM states: RUN, SET_IDLE, HOLD_MIN, HOLD_HR.
- RUN:
  - Prescaler advances while enable=1 and holds its value while enable=0.
  - tick_1s pulses when the prescaler equals TICK_CYC-1. The prescaler then wraps to 0.
  - hr/min presses are ignored.
  - A set press goes to SET_IDLE, pulses sec_clr, and clears the prescaler.
- SET_IDLE:
  - Prescaler is held at 0 and tick_1s is suppressed.
  - A min press pulses min_inc and goes to HOLD_MIN.
  - Otherwise, an hr press pulses hr_inc and goes to HOLD_HR.
  - If both are pressed in the same cycle, minute wins and the hour press is dropped.
  - A set press goes to RUN. The first tick comes TICK_CYC cycles after exit.
- HOLD_MIN / HOLD_HR:
  - A repeat counter starts at 0.
  - After REPEAT_DELAY_CYC cycles, one inc pulse is issued. A further pulse follows every REPEAT_RATE_CYC cycles while the button stays down.
  - Releasing the held button goes to SET_IDLE with no pulse.
  - Presses of the other adjust button are ignored.
- A set press in any state other than RUN goes to RUN. This takes priority over a hold or a release in the same cycle.
- Output pulses are registered. At most one of min_inc/hr_inc is high in any cycle. sec_clr and an inc pulse never coincide.

## Timing
- Reset (async assert, sync deassert expected upstream):
  - state RUN.
  - All outputs 0.
  - Prescaler, repeat counter, debounce counters and debounced levels all 0.
- Reset mid-hold aborts the hold with no pulse.
- Press latency: a raw edge that is stable from clock edge N produces its pulse/transition registered at edge N+DEBOUNCE_CYC+3.
- tick_1s period is exactly TICK_CYC cycles with enable held high. Deasserting enable stretches the period by exactly the number of cycles enable was low.
- Auto-repeat timing: first pulse at press+REPEAT_DELAY_CYC, later pulses at press+REPEAT_DELAY_CYC+k·REPEAT_RATE_CYC.
- Counter widths are $clog2 of the respective parameter. All compares are equality compares, so no overflow is possible.

## Configuration
- TIME_SET_AUTOREPEAT_EN defined: the HOLD behaviour is as described above.
- TIME_SET_AUTOREPEAT_EN undefined:
  - The repeat counter is not built.
  - A held button produces only the initial pulse.
  - HOLD states only wait for release.
  - REPEAT_* parameters are unused.

## Structure
- Shared package time_ctrl_pkg holds:
  - the FSM state enum (RUN, SET_IDLE, HOLD_MIN, HOLD_HR);
  - default cycle constants;
  - a width helper used by the counters.
- One sub-module, btn_debounce (synchronizer + debounce counter, outputs debounced level and a one-cycle press pulse), instantiated three times.

## Test plan
Bench parameters: TICK_CYC=100, DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=40, REPEAT_RATE_CYC=10.
- Free run: enable=1 for 1000 cycles -> 10 tick_1s pulses, exactly 100 apart. Drop enable for 37 cycles -> the next gap is 137.
- Bounce: btn_min toggles every 5 cycles for 60 cycles, then settles high -> no pulse during the bounce; exactly one min_inc 11 cycles after settling (SET mode).
- Set entry: set press -> set_mode=1, one sec_clr, no tick for 500 cycles. Second set press -> set_mode=0; first tick 100 cycles later.
- Hold: btn_hr held 100 cycles after debounce in SET -> hr_inc at press, +40, +50, +60, ... +100. Release -> no further pulses. With the macro undefined -> single pulse.
- Simultaneous btn_hr and btn_min rise in SET_IDLE -> min_inc only, HOLD_MIN. A hr release during the hold has no effect.
- rst_n low during HOLD_MIN -> all outputs 0 immediately, set_mode=0. After release, no pulse until a fresh debounced press.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller: FSM state
// encoding, default cycle counts and the counter width helper.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_IDLE = 2'd1,
    HOLD_MIN = 2'd2,
    HOLD_HR  = 2'd3
  } state_t;

  localparam int DEF_TICK_CYC         = 100_000_000;
  localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYC = 50_000_000;
  localparam int DEF_REPEAT_RATE_CYC  = 10_000_000;

  // Width of a counter that has to hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a debounce
// counter. The debounced level only follows the synchronized input after
// it has disagreed for DEBOUNCE_CYC consecutive cycles; any bounce restarts
// the count. o_press is a registered one-cycle pulse on the level's rise.
module btn_debounce
  import time_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  // Synchronize, count disagreement cycles, commit the level, detect the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer for the digital clock. Owns the 1 s prescaler and
// the RUN / SET_IDLE / HOLD_MIN / HOLD_HR state machine, and turns the three
// debounced pushbuttons into registered single-cycle command pulses.
// Build option: define TIME_SET_AUTOREPEAT_EN to add hold-to-repeat on the
// minute/hour buttons; without it a hold yields only the initial pulse.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int TICK_CYC         = DEF_TICK_CYC,
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn_set,
  input  logic btn_hr,
  input  logic btn_min,
  output logic tick_1s,
  output logic min_inc,
  output logic hr_inc,
  output logic sec_clr,
  output logic set_mode
);

  localparam int            PW       = cnt_w(TICK_CYC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);

  logic w_set_lvl, w_set_press;
  logic w_hr_lvl,  w_hr_press;
  logic w_min_lvl, w_min_press;
  logic w_unused_set_lvl;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_set (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_set), .o_level(w_set_lvl), .o_press(w_set_press)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_hr (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_hr), .o_level(w_hr_lvl), .o_press(w_hr_press)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_min (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_min), .o_level(w_min_lvl), .o_press(w_min_press)
  );

  // The set button only acts on its press edge; its level is not needed.
  assign w_unused_set_lvl = w_set_lvl;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_tick,  w_tick_nxt;
  logic          r_min,   w_min_nxt;
  logic          r_hr,    w_hr_nxt;
  logic          r_clr,   w_clr_nxt;
  logic          w_rep_fire;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int            RW        = (cnt_w(REPEAT_DELAY_CYC) > cnt_w(REPEAT_RATE_CYC)) ?
                                        cnt_w(REPEAT_DELAY_CYC) : cnt_w(REPEAT_RATE_CYC);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYC - 1);

  logic [RW-1:0] r_rep;
  logic          r_rep_ph;
  logic          w_holding;

  assign w_holding = (r_state == HOLD_MIN) || (r_state == HOLD_HR);

  // Fire at the end of the initial delay, then at the end of each rate period.
  always_comb begin
    w_rep_fire = r_rep_ph ? (r_rep == RATE_LAST) : (r_rep == DLY_LAST);
  end

  // Repeat counter: parked at 0 outside a hold, so every hold starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b0;
    end else if (!w_holding) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep    <= '0;
      r_rep_ph <= 1'b1;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_CYC + REPEAT_RATE_CYC;
  assign w_rep_fire = 1'b0;
`endif

  // Next state, prescaler update and command pulses; set press always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_min_nxt   = 1'b0;
    w_hr_nxt    = 1'b0;
    w_clr_nxt   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_set_press) begin
          w_state_nxt = SET_IDLE;
          w_clr_nxt   = 1'b1;
          w_presc_nxt = '0;
        end else if (enable) begin
          if (r_presc == PRE_LAST) begin
            w_tick_nxt  = 1'b1;
            w_presc_nxt = '0;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
      end
      SET_IDLE: begin
        w_presc_nxt = '0;
        if (w_set_press) begin
          w_state_nxt = RUN;
        end else if (w_min_press) begin
          w_min_nxt   = 1'b1;
          w_state_nxt = HOLD_MIN;
        end else if (w_hr_press) begin
          w_hr_nxt    = 1'b1;
          w_state_nxt = HOLD_HR;
        end
      end
      HOLD_MIN: begin
        w_presc_nxt = '0;
        if (w_set_press) begin
          w_state_nxt = RUN;
        end else if (!w_min_lvl) begin
          w_state_nxt = SET_IDLE;
        end else if (w_rep_fire) begin
          w_min_nxt = 1'b1;
        end
      end
      HOLD_HR: begin
        w_presc_nxt = '0;
        if (w_set_press) begin
          w_state_nxt = RUN;
        end else if (!w_hr_lvl) begin
          w_state_nxt = SET_IDLE;
        end else if (w_rep_fire) begin
          w_hr_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_presc_nxt = '0;
      end
    endcase
  end

  // State, prescaler and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_min   <= 1'b0;
      r_hr    <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
      r_min   <= w_min_nxt;
      r_hr    <= w_hr_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  assign tick_1s  = r_tick;
  assign min_inc  = r_min;
  assign hr_inc   = r_hr;
  assign sec_clr  = r_clr;
  assign set_mode = (r_state != RUN);

endmodule
